// File: rtl/mips_harvard_mem_responder.sv
// Harvard-style memory responder for a MIPS CPU under test.
// Preloads separate instruction and data stores, then serves
// combinational instruction and data reads. Data writes commit on the clock
// edge. Protocol faults are detected and latched, committed data accesses
// are counted, and CPU stalls can be inserted from an LFSR.
module mips_harvard_mem_responder #(
  parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
  parameter int unsigned INSTR_WORDS = 256,
  parameter logic [31:0] DATA_BASE   = 32'h00000000,
  parameter int unsigned DATA_WORDS  = 256,
  parameter bit          STALL_EN    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        load_target,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  localparam int unsigned IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int unsigned DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_lfsr;
  logic        r_fault;
  logic [1:0]  r_fault_code;
  logic [15:0] r_read_count;
  logic [15:0] r_write_count;

  // Stores are deliberately left without reset so contents survive reset.
  logic [31:0] r_imem [INSTR_WORDS];
  logic [31:0] r_dmem [DATA_WORDS];

  logic [31:0] w_instr_idx;
  logic        w_instr_ok;
  logic [31:0] w_data_idx;
  logic        w_data_aligned;
  logic        w_data_inrange;
  logic        w_run;
  logic        w_lfsr_en;
  logic        w_access;
  logic [1:0]  w_fault_code;
  logic        w_fault_hit;
  logic        w_read_commit;
  logic        w_write_commit;
  logic [31:0] w_load_idx;
  logic        w_load_instr;
  logic        w_load_data;

  // Address decode: an address below base wraps high and falls out of range.
  assign w_instr_idx    = (instr_address - INSTR_BASE) >> 2;
  assign w_instr_ok     = (instr_address[1:0] == 2'b00) && (w_instr_idx < INSTR_WORDS);
  assign w_data_idx     = (data_address - DATA_BASE) >> 2;
  assign w_data_aligned = (data_address[1:0] == 2'b00);
  assign w_data_inrange = (w_data_idx < DATA_WORDS);

  assign w_run      = (r_state == S_RUN);
  assign w_lfsr_en  = !STALL_EN || (r_lfsr[1:0] != 2'b00);
  assign clk_enable = w_run && w_lfsr_en;
  assign load_ready = (r_state == S_LOAD);

  assign w_access = clk_enable && (data_read || data_write);

  // Fault classification in priority order; 00 means no fault this cycle.
  always_comb begin
    w_fault_code = '0;
    if (w_access) begin
      if (data_read && data_write) begin
        w_fault_code = 2'b11;
      end else if (!w_data_aligned) begin
        w_fault_code = 2'b01;
      end else if (!w_data_inrange) begin
        w_fault_code = 2'b10;
      end
    end
  end

  assign w_fault_hit    = (w_fault_code != 2'b00);
  assign w_read_commit  = clk_enable && data_read && !w_fault_hit;
  // Reset on the same edge aborts the write so memory is left untouched.
  assign w_write_commit = clk_enable && data_write && !w_fault_hit && !reset;

  assign w_load_idx   = {24'h000000, load_addr};
  assign w_load_instr = (r_state == S_LOAD) && load_valid && !load_target &&
                        (w_load_idx < INSTR_WORDS) && !reset;
  assign w_load_data  = (r_state == S_LOAD) && load_valid && load_target &&
                        (w_load_idx < DATA_WORDS) && !reset;

  // Reads are combinational; a same-cycle write only lands at the edge.
  assign instr_readdata = w_instr_ok ? r_imem[w_instr_idx[IAW-1:0]] : '0;
  assign data_readdata  = (data_read && w_run && w_data_aligned && w_data_inrange) ?
                          r_dmem[w_data_idx[DAW-1:0]] : '0;

  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign read_count  = r_read_count;
  assign write_count = r_write_count;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: LOAD -> RUN on load_done, RUN -> FAULT on any fault.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  if (load_done) w_state_next = S_RUN;
      S_RUN:   if (w_fault_hit) w_state_next = S_FAULT;
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_LOAD;
    endcase
  end

  // Sticky fault flag and code, captured once when leaving RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_fault_code <= '0;
    end else if (w_run && w_fault_hit) begin
      r_fault      <= 1'b1;
      r_fault_code <= w_fault_code;
    end
  end

  // Stall LFSR (x^4+x^3+1), stepping on every RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 4'b1001;
    end else if (w_run) begin
      r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end
  end

  // Saturating counters of committed data reads and writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_count  <= '0;
      r_write_count <= '0;
    end else begin
      if (w_read_commit && (r_read_count != 16'hFFFF)) begin
        r_read_count <= r_read_count + 16'd1;
      end
      if (w_write_commit && (r_write_count != 16'hFFFF)) begin
        r_write_count <= r_write_count + 16'd1;
      end
    end
  end

  // Instruction store: written only by preload.
  always_ff @(posedge clk) begin
    if (w_load_instr) begin
      r_imem[w_load_idx[IAW-1:0]] <= load_data;
    end
  end

  // Data store: preload in LOAD, CPU writes in RUN (never both on one edge).
  always_ff @(posedge clk) begin
    if (w_load_data) begin
      r_dmem[w_load_idx[DAW-1:0]] <= load_data;
    end else if (w_write_commit) begin
      r_dmem[w_data_idx[DAW-1:0]] <= data_writedata;
    end
  end

endmodule
